// File: rtl/truth_table_capture_if.sv
// Bundle of sweep-side and result signals for truth_table_capture.
// TTC_FIRST_FAIL_EN adds the first-failing-code result signals.
interface truth_table_capture_if #(
    parameter int IN_W = 5
);
    localparam int N = 1 << IN_W;

    logic            start;
    logic            x_valid;
    logic [IN_W-1:0] x_in;
    logic            y_in;
    logic [N-1:0]    exp_table;
    logic [N-1:0]    table_out;
    logic [N-1:0]    covered;
    logic            busy;
    logic            done;
    logic            pass;
    logic [IN_W:0]   mismatch_cnt;
    logic            overrun_err;
    logic            conflict_err;
`ifdef TTC_FIRST_FAIL_EN
    logic [IN_W-1:0] first_fail_idx;
    logic            first_fail_vld;

    modport master (
        output start, x_valid, x_in, y_in, exp_table,
        input  table_out, covered, busy, done, pass, mismatch_cnt,
               overrun_err, conflict_err, first_fail_idx, first_fail_vld
    );
    modport slave (
        input  start, x_valid, x_in, y_in, exp_table,
        output table_out, covered, busy, done, pass, mismatch_cnt,
               overrun_err, conflict_err, first_fail_idx, first_fail_vld
    );
`else
    modport master (
        output start, x_valid, x_in, y_in, exp_table,
        input  table_out, covered, busy, done, pass, mismatch_cnt,
               overrun_err, conflict_err
    );
    modport slave (
        input  start, x_valid, x_in, y_in, exp_table,
        output table_out, covered, busy, done, pass, mismatch_cnt,
               overrun_err, conflict_err
    );
`endif
endinterface

// File: rtl/truth_table_capture.sv
// Records a combinational DUT's 1-bit response per input code and checks the full table.
// TTC_FIRST_FAIL_EN adds first_fail_idx / first_fail_vld computed at CHECK.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// ARMED  | waiting for the next x_valid
// SETTLE | settle counter running, y_in sampled when it reaches 0
// SAMPLE | write the sampled bit into the table, update coverage
// CHECK  | compare table against exp_table
// DONE   | results held until start
module truth_table_capture #(
    parameter int IN_W          = 5,
    parameter int SETTLE_CYCLES = 4
) (
    input logic                 clk,
    input logic                 rst,
    truth_table_capture_if.slave bus
);
    localparam int N     = 1 << IN_W;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [IN_W-1:0] x_q;
    logic            y_q;
    logic [N-1:0]    table_q;
    logic [N-1:0]    covered_q;
    logic [IN_W:0]   mismatch_q;
    logic            pass_q;
    logic            overrun_q;
    logic            conflict_q;

    logic clear_all, latch_x, cnt_dec, set_overrun, capture_y, write_en, check_en;
    logic [N-1:0]  sel_onehot;
    logic [N-1:0]  diff;
    logic [IN_W:0] diff_cnt;

    function automatic logic [IN_W:0] popcount(input logic [N-1:0] v);
        logic [IN_W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + (IN_W+1)'(v[i]);
        return c;
    endfunction

    assign sel_onehot = N'(1) << x_q;
    assign diff       = table_q ^ bus.exp_table;
    assign diff_cnt   = popcount(diff);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        clear_all   = 1'b0;
        latch_x     = 1'b0;
        cnt_dec     = 1'b0;
        set_overrun = 1'b0;
        capture_y   = 1'b0;
        write_en    = 1'b0;
        check_en    = 1'b0;
        if (bus.start) begin
            clear_all = 1'b1;
            state_d   = ARMED;
        end else begin
            case (state_q)
                IDLE: ;
                ARMED: begin
                    if (bus.x_valid) begin
                        latch_x = 1'b1;
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    // A new code restarts settling; the last code wins.
                    if (bus.x_valid) begin
                        latch_x     = 1'b1;
                        set_overrun = 1'b1;
                    end else if (cnt_q == '0) begin
                        capture_y = 1'b1;
                        state_d   = SAMPLE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                SAMPLE: begin
                    write_en = 1'b1;
                    state_d  = ((covered_q | sel_onehot) == {N{1'b1}}) ? CHECK : ARMED;
                end
                CHECK: begin
                    check_en = 1'b1;
                    state_d  = DONE;
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            table_q    <= '0;
            covered_q  <= '0;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
            overrun_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            if (set_overrun) overrun_q <= 1'b1;
            if (write_en) begin
                if (covered_q[x_q] && (table_q[x_q] != y_q)) conflict_q <= 1'b1;
                table_q[x_q]   <= y_q;
                covered_q[x_q] <= 1'b1;
            end
            if (check_en) begin
                mismatch_q <= diff_cnt;
                pass_q     <= (diff_cnt == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            x_q   <= '0;
            y_q   <= 1'b0;
        end else begin
            if (latch_x) begin
                x_q   <= bus.x_in;
                cnt_q <= CNT_LOAD;
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (capture_y) y_q <= bus.y_in;
        end
    end

`ifdef TTC_FIRST_FAIL_EN
    logic [IN_W-1:0] ff_idx_d, ff_idx_q;
    logic            ff_vld_q;

    // Scan downwards so the lowest differing index is the one that sticks.
    always_comb begin
        ff_idx_d = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (diff[i]) ff_idx_d = IN_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            ff_idx_q <= '0;
            ff_vld_q <= 1'b0;
        end else if (check_en) begin
            ff_idx_q <= ff_idx_d;
            ff_vld_q <= (diff_cnt != '0);
        end
    end

    assign bus.first_fail_idx = ff_idx_q;
    assign bus.first_fail_vld = ff_vld_q;
`endif

    assign bus.table_out    = table_q;
    assign bus.covered      = covered_q;
    assign bus.busy         = (state_q == SETTLE);
    assign bus.done         = (state_q == DONE);
    assign bus.pass         = pass_q;
    assign bus.mismatch_cnt = mismatch_q;
    assign bus.overrun_err  = overrun_q;
    assign bus.conflict_err = conflict_q;
endmodule
